// File: rtl/nios_led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_led_pkg
// Purpose  : Shared definitions for the Nios II LED output PIO: word register
//            addresses and the blink period field width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nios_led_pkg;

    localparam int ADDR_W   = 3;
    localparam int PERIOD_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/nios_led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : nios_led_tick_gen
// Purpose  : Blink prescaler. Asserts tick for one clk cycle every PRESCALE
//            cycles; clear restarts the count from zero.
// Ports    : clk     - system clock
//            reset_n - asynchronous active-low reset
//            clear   - synchronous restart of the prescaler count
//            tick    - one-cycle pulse, every PRESCALE cycles
// Revision : 1.0 - initial release
// ============================================================================
module nios_led_tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With PRESCALE=1 the counter sits at 0 and tick is permanently high.
    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios_led_pio_out.sv
`default_nettype none
// ============================================================================
// Module   : nios_led_pio_out
// Purpose  : Avalon-MM output PIO driving board LEDs. Holds a software output
//            register with atomic set/clear access and a per-bit hardware
//            blink engine paced by a tick prescaler.
// Ports    : clk, reset_n        - clock, asynchronous active-low reset
//            chipselect, address - slave select and word register index
//            write_n, writedata  - active-low write strobe and write data
//            readdata            - registered read data (1 cycle latency)
//            out_port            - active-high LED drive
// Revision : 1.0 - initial release
// ============================================================================
module nios_led_pio_out
    import nios_led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [2:0]        address,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0]    data_q,   data_d;
    logic [WIDTH-1:0]    blink_q,  blink_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q,    cnt_d;
    logic                phase_q,  phase_d;
    logic [31:0]         readdata_q, readdata_d;

    logic                w_wr;
    logic                w_period_wr;
    logic                w_tick;
    logic [WIDTH-1:0]    w_wd;
    logic [31:0]         w_status;
    logic                w_unused_ok;

    assign w_wr        = chipselect && !write_n;
    assign w_period_wr = w_wr && (address == ADDR_PERIOD);
    assign w_wd        = writedata[WIDTH-1:0];

    // Upper writedata bits beyond the field widths are intentionally dropped.
    assign w_unused_ok = ^writedata;

    nios_led_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_period_wr),
        .tick    (w_tick)
    );

    // Register file
    always_comb begin
        data_d   = data_q;
        blink_d  = blink_q;
        period_d = period_q;
        if (w_wr) begin
            case (address)
                ADDR_DATA:     data_d   = w_wd;
                ADDR_BLINK:    blink_d  = w_wd;
                ADDR_PERIOD:   period_d = writedata[PERIOD_W-1:0];
                ADDR_OUTSET:   data_d   = data_q | w_wd;
                ADDR_OUTCLEAR: data_d   = data_q & ~w_wd;
                default:       ;
            endcase
        end
    end

    // Blink counter / phase. A PERIOD write restarts the half-period from
    // scratch and wins over any tick or wrap on the same edge, so lowering
    // PERIOD below the running count can never cause a long runaway.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (w_period_wr || (period_q == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (w_tick) begin
            if (cnt_q == period_q - PERIOD_W'(1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + PERIOD_W'(1);
            end
        end
    end

    assign out_port = data_q & ~(blink_q & {WIDTH{phase_q}});

    // Phase owns bit 31 of STATUS even when WIDTH reaches 32.
    always_comb begin
        w_status     = 32'(out_port);
        w_status[31] = phase_q;
    end

    always_comb begin
        readdata_d = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:   readdata_d = 32'(data_q);
                ADDR_BLINK:  readdata_d = 32'(blink_q);
                ADDR_PERIOD: readdata_d = 32'(period_q);
                ADDR_STATUS: readdata_d = w_status;
                default:     readdata_d = '0;
            endcase
        end
    end

    assign readdata = readdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            blink_q    <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            blink_q    <= blink_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_led_pio_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_led_pio_out
// Purpose  : Self-checking bench for nios_led_pio_out (WIDTH=8, PRESCALE=4).
//            Reference model derives blink phase from elapsed cycles since
//            the last PERIOD write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_led_pio_out;

    localparam int WIDTH    = 8;
    localparam int PRESCALE = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              chipselect;
    logic [2:0]        address;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  out_port;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state
    logic [7:0]  m_data;
    logic [7:0]  m_blink;
    logic [15:0] m_period;
    int          m_t0;

    nios_led_pio_out #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Phase = number of whole half-periods elapsed since the PERIOD write, mod 2.
    function automatic logic m_phase();
        if (m_period == 16'd0) return 1'b0;
        return (((cyc - m_t0) / (int'(m_period) * PRESCALE)) % 2) == 1;
    endfunction

    function automatic logic [7:0] m_out();
        return m_data & ~(m_blink & {8{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r = {24'd0, m_data};
            3'd1: r = {24'd0, m_blink};
            3'd2: r = {16'd0, m_period};
            3'd5: begin
                r     = {24'd0, m_out()};
                r[31] = m_phase();
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_data   = 8'd0;
        m_blink  = 8'd0;
        m_period = 16'd0;
        m_t0     = cyc;
    endtask

    // Entered and left just after a falling edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        case (a)
            3'd0: m_data  = d[7:0];
            3'd1: m_blink = d[7:0];
            3'd2: begin
                m_period = d[15:0];
                m_t0     = cyc + 1;
            end
            3'd3: m_data = m_data | d[7:0];
            3'd4: m_data = m_data & ~d[7:0];
            default: ;
        endcase
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] got,
                            output logic [31:0] exp);
        exp        = m_read(a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(negedge clk);
        got        = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        vectors++;
        if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_port: got %h expected 00", out_port);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), got, exp);
            vectors++;
            if (got !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr %0d: got %h expected 00000000", a, got);
            end
        end
    endtask

    task automatic test_data_access();
        logic [31:0] got, exp;
        bus_write(3'd0, 32'h1A5);
        bus_read(3'd0, got, exp);
        vectors++;
        if (got !== 32'h0000_00A5 || out_port !== 8'hA5) begin
            errors++;
            $display("FAIL data_write: got rd=%h out=%h expected rd=000000a5 out=a5", got, out_port);
        end
        bus_write(3'd3, 32'h0F);
        bus_read(3'd0, got, exp);
        vectors++;
        if (got !== 32'h0000_00AF || out_port !== 8'hAF) begin
            errors++;
            $display("FAIL outset: got rd=%h out=%h expected rd=000000af out=af", got, out_port);
        end
        bus_write(3'd4, 32'hA0);
        bus_read(3'd0, got, exp);
        vectors++;
        if (got !== 32'h0000_000F || out_port !== 8'h0F) begin
            errors++;
            $display("FAIL outclear: got rd=%h out=%h expected rd=0000000f out=0f", got, out_port);
        end
        for (int a = 3; a <= 4; a++) begin
            bus_read(3'(a), got, exp);
            vectors++;
            if (got !== 32'd0) begin
                errors++;
                $display("FAIL setclr_read addr %0d: got %h expected 00000000", a, got);
            end
        end
    endtask

    task automatic test_blink();
        logic [31:0] got, exp;
        logic [7:0]  want;
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'h0F);
        bus_write(3'd2, 32'd3);
        for (int i = 0; i < 36; i++) begin
            want = ((i / 12) % 2 == 1) ? 8'hF0 : 8'hFF;
            vectors++;
            if (out_port !== want) begin
                errors++;
                $display("FAIL blink elapsed %0d: got %h expected %h", i, out_port, want);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            bus_read(3'd5, got, exp);
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL blink_status: got %h expected %h", got, exp);
            end
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_period_zero();
        logic [31:0] got, exp;
        int guard;
        guard = 0;
        while (m_phase() != 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (out_port !== 8'hF0) begin
            errors++;
            $display("FAIL pz_precondition: got %h expected f0", out_port);
        end
        bus_write(3'd2, 32'd0);
        for (int i = 0; i < 100; i++) begin
            vectors++;
            if (out_port !== 8'hFF) begin
                errors++;
                $display("FAIL period_zero cycle %0d: got %h expected ff", i, out_port);
            end
            @(negedge clk);
        end
        bus_read(3'd5, got, exp);
        vectors++;
        if (got !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL period_zero_status: got %h expected 000000ff", got);
        end
    endtask

    task automatic test_wrap_rewrite();
        logic [7:0] want;
        bus_write(3'd2, 32'd3);
        while (cyc < m_t0 + 11) @(negedge clk);
        vectors++;
        if (out_port !== 8'hFF) begin
            errors++;
            $display("FAIL pre_wrap: got %h expected ff", out_port);
        end
        // This write lands on the edge that would have toggled the phase.
        bus_write(3'd2, 32'd2);
        for (int i = 0; i < 12; i++) begin
            want = (i >= 8) ? 8'hF0 : 8'hFF;
            vectors++;
            if (out_port !== want) begin
                errors++;
                $display("FAIL wrap_rewrite elapsed %0d: got %h expected %h", i, out_port, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [31:0] got, exp;
        int guard;
        bus_write(3'd2, 32'd1);
        guard = 0;
        while (m_phase() != 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 3'd0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_port !== 8'h00 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got out=%h rd=%h expected out=00 rd=00000000", out_port, readdata);
        end
        chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), got, exp);
            vectors++;
            if (got !== 32'd0) begin
                errors++;
                $display("FAIL post_reset_read addr %0d: got %h expected 00000000", a, got);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp, d;
        logic [2:0]  a;
        for (int n = 0; n < 300; n++) begin
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                if (a == 3'd2) d = {d[31:16], 16'($urandom_range(0, 3))};
                bus_write(a, d);
            end else begin
                bus_read(a, got, exp);
                vectors++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_read addr %0d op %0d: got %h expected %h", a, n, got, exp);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vectors++;
            if (out_port !== m_out()) begin
                errors++;
                $display("FAIL random_out op %0d: got %h expected %h", n, out_port, m_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_access();
        test_blink();
        test_period_zero();
        test_wrap_rewrite();
        test_reset_mid_blink();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
